cs_result_drain: RTL and testbench

Consumes the carry-save partial results `{acc_sum, acc_carry}` that leave the bottom PE of a systolic column, and resolves each pair into one two's-complement accumulator value through a pipelined split adder. Results are buffered in a small FIFO and streamed out over a valid/ready handshake, with a per-tile `last` marker. One instance sits under each array column. It is the read-side counterpart of the PE carry-save output format.

---
 rtl/cs_drain_pkg.sv | 51 +++++
 rtl/cs_drain_fifo.sv | 98 +++++++++
 rtl/cs_result_drain.sv | 188 ++++++++++++++++++
 tb/tb_cs_result_drain.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cs_drain_pkg.sv
// ---------------------------------------------------------------------------
// cs_drain_pkg
// Shared constants and helpers for the carry-save result drain.
//   - Default parameter values for cs_result_drain.
//   - Low-half split width used by the two-stage split adder.
//   - sat_shift(): arithmetic shift followed by signed saturation, used by
//     the optional saturation stage (enabled with macro CS_DRAIN_SAT_EN).
// ---------------------------------------------------------------------------
package cs_drain_pkg;

  localparam int DEF_ACC_WIDTH  = 24;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_TILE_LEN   = 16;
  localparam int DEF_OUT_WIDTH  = 8;
  localparam int DEF_SHIFT      = 0;

  // Low half of the split adder for the default width (rounded down).
  localparam int DEF_LO_WIDTH   = DEF_ACC_WIDTH / 2;

  // Working width of the saturation helper; accumulators up to 64 bits.
  localparam int SAT_CALC_WIDTH = 64;

  // Low-half split width for an arbitrary accumulator width.
  function automatic int lo_width(input int acc_width);
    return acc_width / 2;
  endfunction

  // Arithmetic right shift by 'shift', then clamp to the signed range of
  // 'out_width' bits. The caller sign-extends its value to SAT_CALC_WIDTH
  // and truncates the result back to its own width.
  function automatic logic signed [SAT_CALC_WIDTH-1:0] sat_shift(
    input logic signed [SAT_CALC_WIDTH-1:0] value,
    input int                               shift,
    input int                               out_width
  );
    logic signed [SAT_CALC_WIDTH-1:0] shifted;
    logic signed [SAT_CALC_WIDTH-1:0] max_v;
    logic signed [SAT_CALC_WIDTH-1:0] min_v;
    shifted = value >>> shift;
    max_v   = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (out_width - 1));
    if (shifted > max_v) begin
      return max_v;
    end
    if (shifted < min_v) begin
      return min_v;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/cs_drain_fifo.sv
// ---------------------------------------------------------------------------
// cs_drain_fifo
// Show-ahead FIFO with a registered head entry. The head register always
// holds the entry that will be visible next, so head_data is a flop output
// and stays stable while the consumer stalls. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous flush of pointers, count and head
//   push         write request, push_data is the value to store
//   pop          read request (ignored when empty)
//   head_data    registered head entry
//   full, empty  occupancy flags derived from the registered count
//   level        occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module cs_drain_fifo
  import cs_drain_pkg::*;
#(
  parameter int WIDTH = DEF_ACC_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic             do_push;
  logic             do_pop;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count_next;
  logic [WIDTH-1:0] head_next;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

  // A full FIFO frees a slot in the same cycle it is popped, so the push is
  // allowed through in that case.
  assign do_pop      = pop && !empty;
  assign do_push     = push && (!full || do_pop);
  assign rd_ptr_next = rd_ptr + AW'(do_pop);
  assign count_next  = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

  // Next head: the entry at the next read pointer, or the incoming data
  // when it is being written into exactly that slot (FIFO empty, or
  // draining its last entry while a new one arrives).
  always_comb begin
    head_next = mem[rd_ptr_next];
    if (do_push && (wr_ptr == rd_ptr_next)) begin
      head_next = push_data;
    end
  end

  // Storage array; no reset needed since the count qualifies every entry.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_data <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      head_data <= head_next;
    end
  end

endmodule

// File: rtl/cs_result_drain.sv
// ---------------------------------------------------------------------------
// cs_result_drain
// Resolves the carry-save pair leaving the bottom PE of a systolic column
// into one two's-complement accumulator value, buffers results in a small
// FIFO and streams them out over valid/ready with a per-tile last marker.
//
// Optional feature: define macro CS_DRAIN_SAT_EN to add a third register
// stage that arithmetically shifts right by SHIFT and saturates to a signed
// OUT_WIDTH range (sign-extended to ACC_WIDTH). Without the macro OUT_WIDTH
// and SHIFT are ignored and o_data is the raw resolved value.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clear      synchronous flush of pipeline, FIFO, tile count, overflow
//   i_y_p        {sum, carry}, each ACC_WIDTH bits
//   i_valid      i_y_p valid this cycle (no backpressure upstream)
//   o_data       resolved result (signed), registered FIFO head
//   o_valid      FIFO not empty
//   i_ready      downstream accepts; pop = o_valid && i_ready
//   o_last       o_data is the last result of a tile
//   o_overflow   sticky: a result was dropped on a full FIFO
//   o_level      FIFO occupancy
// ---------------------------------------------------------------------------
module cs_result_drain
  import cs_drain_pkg::*;
#(
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TILE_LEN   = DEF_TILE_LEN,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int SHIFT      = DEF_SHIFT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_clear,
  input  logic [2*ACC_WIDTH-1:0]        i_y_p,
  input  logic                          i_valid,
  output logic [ACC_WIDTH-1:0]          o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_last,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int LO_W = lo_width(ACC_WIDTH);
  localparam int HI_W = ACC_WIDTH - LO_W;
  localparam int TW   = (TILE_LEN > 1) ? $clog2(TILE_LEN) : 1;
  localparam logic [TW-1:0] TILE_MAX = TW'(TILE_LEN - 1);

  logic [ACC_WIDTH-1:0] sum_in;
  logic [ACC_WIDTH-1:0] carry_in;
  logic [LO_W:0]        lo_add;

  logic                 s1_valid;
  logic [LO_W-1:0]      s1_lo;
  logic                 s1_co;
  logic [HI_W-1:0]      s1_sum_hi;
  logic [HI_W-1:0]      s1_car_hi;

  logic [HI_W-1:0]      hi_add;
  logic                 s2_valid;
  logic [ACC_WIDTH-1:0] s2_data;

  logic                 fin_valid;
  logic [ACC_WIDTH-1:0] fin_data;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic [TW-1:0]        tile_cnt;
  logic                 overflow_q;

  assign sum_in   = i_y_p[2*ACC_WIDTH-1:ACC_WIDTH];
  assign carry_in = i_y_p[ACC_WIDTH-1:0];

  // Low halves are added with one extra bit so the carry into the high
  // half can be registered alongside the low sum.
  assign lo_add = {1'b0, sum_in[LO_W-1:0]} + {1'b0, carry_in[LO_W-1:0]};

  // Stage 1: low-half add, carry-out and both high halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_lo     <= '0;
      s1_co     <= 1'b0;
      s1_sum_hi <= '0;
      s1_car_hi <= '0;
    end else begin
      s1_valid  <= i_valid && !i_clear;
      s1_lo     <= lo_add[LO_W-1:0];
      s1_co     <= lo_add[LO_W];
      s1_sum_hi <= sum_in[ACC_WIDTH-1:LO_W];
      s1_car_hi <= carry_in[ACC_WIDTH-1:LO_W];
    end
  end

  // The carry out of the high half is the modulo wrap and is discarded.
  assign hi_add = s1_sum_hi + s1_car_hi + HI_W'(s1_co);

  // Stage 2: high-half add joined with the registered low sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid && !i_clear;
      s2_data  <= {hi_add, s1_lo};
    end
  end

`ifdef CS_DRAIN_SAT_EN
  logic                 s3_valid;
  logic [ACC_WIDTH-1:0] s3_data;

  // Stage 3: shift and saturate; the helper works on a sign-extended copy
  // and the low ACC_WIDTH bits carry the sign-extended clamped result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_data  <= '0;
    end else begin
      s3_valid <= s2_valid && !i_clear;
      s3_data  <= ACC_WIDTH'(sat_shift(SAT_CALC_WIDTH'(signed'(s2_data)),
                                       SHIFT, OUT_WIDTH));
    end
  end

  assign fin_valid = s3_valid;
  assign fin_data  = s3_data;
`else
  assign fin_valid = s2_valid;
  assign fin_data  = s2_data;
`endif

  assign o_valid = !fifo_empty;
  assign pop     = o_valid && i_ready;

  cs_drain_fifo #(
    .WIDTH (ACC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (i_clear),
    .push      (fin_valid),
    .push_data (fin_data),
    .pop       (pop),
    .head_data (o_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (o_level)
  );

  // Sticky overflow: set when a result arrives on a full FIFO that is not
  // being popped in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (i_clear) begin
      overflow_q <= 1'b0;
    end else if (fin_valid && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  assign o_overflow = overflow_q;

  // Tile counter: index of the result currently at the head, advanced on
  // every pop and wrapped after the last result of a tile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_cnt <= '0;
    end else if (i_clear) begin
      tile_cnt <= '0;
    end else if (pop) begin
      if (o_last) begin
        tile_cnt <= '0;
      end else begin
        tile_cnt <= tile_cnt + TW'(1);
      end
    end
  end

  // With TILE_LEN=1 TILE_MAX is 0 and the counter never leaves 0.
  assign o_last = o_valid && (tile_cnt == TILE_MAX);

endmodule

// File: tb/tb_cs_result_drain.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cs_result_drain
// Directed and randomized stimulus for cs_result_drain, checked every cycle
// against a queue-based reference model. Honors CS_DRAIN_SAT_EN.
// ---------------------------------------------------------------------------
module tb_cs_result_drain;

  localparam int ACC_W = 24;
  localparam int DEPTH = 4;
  localparam int TILE  = 3;
  localparam int OUT_W = 8;
  localparam int SH    = 0;
`ifdef CS_DRAIN_SAT_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic                       i_clear = 1'b0;
  logic [2*ACC_W-1:0]         i_y_p = '0;
  logic                       i_valid = 1'b0;
  logic                       i_ready = 1'b0;
  logic [ACC_W-1:0]           o_data;
  logic                       o_valid;
  logic                       o_last;
  logic                       o_overflow;
  logic [$clog2(DEPTH):0]     o_level;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int               due;
    logic [ACC_W-1:0] val;
  } flight_t;

  flight_t          flight_q[$];
  logic [ACC_W-1:0] fifo_q[$];
  int               tile_idx = 0;
  bit               ovf = 1'b0;
  int               edge_n = 0;

  cs_result_drain #(
    .ACC_WIDTH  (ACC_W),
    .FIFO_DEPTH (DEPTH),
    .TILE_LEN   (TILE),
    .OUT_WIDTH  (OUT_W),
    .SHIFT      (SH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (i_clear),
    .i_y_p      (i_y_p),
    .i_valid    (i_valid),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_last     (o_last),
    .o_overflow (o_overflow),
    .o_level    (o_level)
  );

  always #5 clk = ~clk;

  // Expected output value for one carry-save pair.
  function automatic logic [ACC_W-1:0] expect_result(logic [ACC_W-1:0] s,
                                                     logic [ACC_W-1:0] c);
    logic [ACC_W-1:0] r;
`ifdef CS_DRAIN_SAT_EN
    longint v;
    longint lim;
`endif
    r = s + c;
`ifdef CS_DRAIN_SAT_EN
    v   = longint'(signed'(r)) >>> SH;
    lim = longint'(1) << (OUT_W - 1);
    if (v > lim - 1) v = lim - 1;
    else if (v < -lim) v = -lim;
    r = ACC_W'(v);
`endif
    return r;
  endfunction

  task automatic model_flush();
    flight_q.delete();
    fifo_q.delete();
    tile_idx = 0;
    ovf      = 1'b0;
  endtask

  // One clock edge of the reference model, using the inputs just sampled.
  task automatic model_edge();
    bit      popped;
    flight_t f;
    popped = (fifo_q.size() > 0) && i_ready;
    edge_n++;
    if (i_clear) begin
      model_flush();
      return;
    end
    if (popped) begin
      void'(fifo_q.pop_front());
      tile_idx = (tile_idx == TILE - 1) ? 0 : tile_idx + 1;
    end
    if (flight_q.size() > 0 && flight_q[0].due == edge_n) begin
      f = flight_q.pop_front();
      if (fifo_q.size() == DEPTH) ovf = 1'b1;
      else fifo_q.push_back(f.val);
    end
    if (i_valid) begin
      f.due = edge_n + LAT - 1;
      f.val = expect_result(i_y_p[2*ACC_W-1:ACC_W], i_y_p[ACC_W-1:0]);
      flight_q.push_back(f);
    end
  endtask

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit ev;
    ev = fifo_q.size() > 0;
    check_output("valid", 32'(o_valid), 32'(ev));
    check_output("level", 32'(o_level), 32'(fifo_q.size()));
    check_output("overflow", 32'(o_overflow), 32'(ovf));
    check_output("last", 32'(o_last), 32'(ev && (tile_idx == TILE - 1)));
    if (ev) check_output("data", 32'(o_data), 32'(fifo_q[0]));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, then check.
  task automatic apply_stimulus(bit v, logic [ACC_W-1:0] s, logic [ACC_W-1:0] c,
                                bit rdy, bit clr);
    i_valid = v;
    i_y_p   = {s, c};
    i_ready = rdy;
    i_clear = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic check_reset_values();
    check_output("rst_data", 32'(o_data), 32'h0);
    check_output("rst_valid", 32'(o_valid), 32'h0);
    check_output("rst_last", 32'(o_last), 32'h0);
    check_output("rst_overflow", 32'(o_overflow), 32'h0);
    check_output("rst_level", 32'(o_level), 32'h0);
  endtask

  initial begin
    logic [ACC_W-1:0] rs;
    logic [ACC_W-1:0] rc;

    // Reset state
    #12;
    check_reset_values();
    rst_n = 1'b1;

    // Basic resolve and latency
    apply_stimulus(1, 24'h000005, 24'h000003, 1, 0);
    repeat (4) apply_stimulus(0, '0, '0, 1, 0);

    // Wrap to -1 and low-half carry into the high half
    apply_stimulus(1, 24'hFFFFFF, 24'h000000, 1, 0);
    apply_stimulus(1, 24'h000FFF, 24'h000001, 1, 0);
    repeat (4) apply_stimulus(0, '0, '0, 1, 0);

    // Saturation values (raw resolve when the stage is absent)
    apply_stimulus(1, 24'd300, 24'h0, 1, 0);
    apply_stimulus(1, 24'hFFFED4, 24'h0, 1, 0);
    apply_stimulus(1, 24'd50, 24'h0, 1, 0);
    repeat (5) apply_stimulus(0, '0, '0, 1, 0);

    // Overflow: six results into a four-entry FIFO with no consumer
    for (int i = 1; i <= 6; i++) apply_stimulus(1, ACC_W'(i), '0, 0, 0);
    repeat (4) apply_stimulus(0, '0, '0, 0, 0);
    repeat (6) apply_stimulus(0, '0, '0, 1, 0);
    apply_stimulus(0, '0, '0, 1, 1);

    // Tile marker with a toggling consumer
    for (int i = 0; i < 7; i++)
      apply_stimulus(1, ACC_W'(16 * i + 7), ACC_W'(i), (i % 2) == 0, 0);
    for (int i = 0; i < 14; i++) apply_stimulus(0, '0, '0, (i % 2) == 1, 0);

    // Clear with two results in flight and three buffered
    for (int i = 0; i < 5; i++) apply_stimulus(1, ACC_W'(100 + i), '0, 0, 0);
    apply_stimulus(0, '0, '0, 0, 1);
    apply_stimulus(1, 24'h000AAA, 24'h000555, 1, 0);
    repeat (5) apply_stimulus(0, '0, '0, 1, 0);

    // Mid-stream asynchronous reset
    for (int i = 0; i < 4; i++) apply_stimulus(1, ACC_W'(200 + i), '0, 0, 0);
    rst_n = 1'b0;
    #2;
    model_flush();
    check_reset_values();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) apply_stimulus(0, '0, '0, 1, 0);

    // Randomized traffic, consumer stalls and occasional clears
    for (int i = 0; i < 600; i++) begin
      rs = ACC_W'($urandom);
      rc = ACC_W'($urandom);
      apply_stimulus($urandom_range(0, 99) < 70, rs, rc,
                     $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 2);
    end
    repeat (12) apply_stimulus(0, '0, '0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
